// File: rtl/stream_frame_mux.sv
// stream_frame_mux
// Merges CHANNELS independent stb/ack word streams into one framed byte
// stream for a UART transmitter. Each accepted word becomes the frame
//   0xFF, channel, data bytes MSB first
// where any data byte equal to 0xFE or 0xFF is sent as 0xFE followed by
// that byte XOR 0x20. Channel numbers are at most 15, so the channel byte
// never needs escaping.
//
// Handshake: a transfer happens on a rising clk edge where stb and ack are
// both high. Upstream, in_ack is driven combinationally while IDLE. Downstream,
// out_stb/out_data are registered and hold steady until out_ack is seen.
//
// Ports
//   clk        sole clock
//   rst        asynchronous, active-high reset
//   in_data    packed input words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_stb     per-channel word valid
//   in_ack     per-channel word accept (one-hot or zero)
//   out_data   byte to the UART transmitter
//   out_stb    byte valid
//   out_ack    byte accepted by the UART transmitter
//   dbg_state  current FSM state (0 IDLE, 1 SYNC, 2 CHAN, 3 DATA, 4 ESC)
module stream_frame_mux #(
  parameter int CHANNELS    = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]            in_stb,
  output logic [CHANNELS-1:0]            in_ack,
  output logic [7:0]                     out_data,
  output logic                           out_stb,
  input  logic                           out_ack,
  output logic [2:0]                     dbg_state
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_CHAN = 3'd2,
    S_DATA = 3'd3,
    S_ESC  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic [CW-1:0]           last_q, last_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_stb_q, out_stb_d;

  logic                    grant_valid;
  logic [CW-1:0]           grant_idx;
  logic [7:0]              cur_byte;
  logic [7:0]              next_byte;
  logic                    last_byte;

  // Arbiter. Round-robin starts one past the previous grant; fixed priority
  // always starts at channel 0. The first requesting channel found wins.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ROUND_ROBIN != 0) idx = (int'(last_q) + 1 + i) % CHANNELS;
      else                  idx = i;
      if (!grant_valid && in_stb[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
  end

  // Words are only accepted between frames; gating with rst keeps the ack
  // quiet while the block is held in reset.
  always_comb begin
    in_ack = '0;
    if (state_q == S_IDLE && !rst && grant_valid) in_ack[grant_idx] = 1'b1;
  end

  // State register (also holds the datapath and registered outputs).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      chan_q     <= '0;
      last_q     <= CW'(CHANNELS - 1);
      out_data_q <= 8'h00;
      out_stb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      chan_q     <= chan_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_stb_q  <= out_stb_d;
    end
  end

  assign cur_byte  = shift_q[DATA_WIDTH-1 -: 8];
  assign last_byte = (cnt_q == 3'(BYTES - 1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          state_d = S_SYNC;
          shift_d = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          chan_d  = grant_idx;
          last_d  = grant_idx;
          cnt_d   = '0;
        end
      end
      S_SYNC: if (out_ack) state_d = S_CHAN;
      S_CHAN: if (out_ack) state_d = S_DATA;
      S_DATA, S_ESC: begin
        if (out_ack) begin
          if (state_q == S_DATA && cur_byte >= 8'hFE) begin
            // Escape marker goes out first; the byte itself follows in ESC.
            state_d = S_ESC;
          end else begin
            shift_d = shift_q << 8;
            if (last_byte) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_DATA;
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the byte for the state being entered, so the registered
  // outputs line up with the state and do not move while out_ack is low.
  assign next_byte = shift_d[DATA_WIDTH-1 -: 8];

  always_comb begin
    out_stb_d  = (state_d != S_IDLE);
    out_data_d = 8'h00;
    unique case (state_d)
      S_SYNC:  out_data_d = 8'hFF;
      S_CHAN:  out_data_d = 8'(chan_d);
      S_DATA:  out_data_d = (next_byte >= 8'hFE) ? 8'hFE : next_byte;
      S_ESC:   out_data_d = next_byte ^ 8'h20;
      default: out_data_d = 8'h00;
    endcase
  end

  assign out_data  = out_data_q;
  assign out_stb   = out_stb_q;
  assign dbg_state = state_q;

endmodule
